// File: rtl/op_sequence_formatter_pkg.sv
// Shared slot-field layout, FSM state encoding and sizing helpers for the
// PMBIST op sequence formatter and its slot decoder.
package op_sequence_formatter_pkg;

  localparam int OP_EN_BIT  = 2;
  localparam int OP_INV_BIT = 1;
  localparam int OP_RW_BIT  = 0;

  localparam int OPW_DEFAULT  = 3;
  localparam int NOPS_DEFAULT = 4;
  localparam int DW_DEFAULT   = 8;

  typedef enum logic {
    OPF_IDLE  = 1'b0,
    OPF_ISSUE = 1'b1
  } opf_state_t;

  // A single-slot element still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/op_sequence_formatter_slot_decode.sv
// Combinational decode of one op slot into read/write strobes and
// background-polarised data; also used for expected-data generation.
module op_slot_decode
  import op_sequence_formatter_pkg::*;
#(
  parameter int OPW = OPW_DEFAULT,
  parameter int DW  = DW_DEFAULT
) (
  input  logic [OPW-1:0] slot,
  input  logic [DW-1:0]  bg,
  output logic           en,
  output logic           we,
  output logic           re,
  output logic [DW-1:0]  data
);

  assign en   = slot[OP_EN_BIT];
  assign we   = slot[OP_RW_BIT];
  assign re   = ~slot[OP_RW_BIT];
  assign data = slot[OP_INV_BIT] ? ~bg : bg;

endmodule

// File: rtl/op_sequence_formatter.sv
// Walks the enabled op slots of one march element and issues them as memory
// commands, one per cycle, with registered outputs and valid/ready on both sides.
module op_sequence_formatter
  import op_sequence_formatter_pkg::*;
#(
  parameter int OPW  = OPW_DEFAULT,
  parameter int NOPS = NOPS_DEFAULT,
  parameter int DW   = DW_DEFAULT,
  parameter int IW   = idx_width(NOPS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [NOPS*OPW-1:0] op_in,
  input  logic [DW-1:0]       bg_in,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic                mem_re,
  output logic [DW-1:0]       mem_data,
  output logic [OPW-1:0]      mem_op,
  output logic [IW-1:0]       mem_slot,
  output logic                elem_done
);

  // Handshakes: a transfer happens on an edge where valid && ready; valid and
  // its payload hold stable until that edge, and ready never depends on valid.

  opf_state_t          state;
  logic [NOPS*OPW-1:0] elem_q;
  logic [DW-1:0]       bg_q;
  logic [IW-1:0]       idx;

  logic [OPW-1:0] src_slot;
  logic [DW-1:0]  src_bg;
  logic           dec_en;
  logic           dec_we;
  logic           dec_re;
  logic [DW-1:0]  dec_data;

  // In IDLE the decoder looks at slot 0 of the incoming word; in ISSUE it looks
  // ahead at the slot after the current one (zero past the end, so it reads as disabled).
  always_comb begin
    src_slot = '0;
    src_bg   = bg_q;
    if (state == OPF_IDLE) begin
      src_slot = op_in[OPW-1:0];
      src_bg   = bg_in;
    end else begin
      for (int i = 0; i < NOPS; i++) begin
        if (i == int'(idx) + 1) src_slot = elem_q[i*OPW +: OPW];
      end
    end
  end

  op_slot_decode #(.OPW(OPW), .DW(DW)) u_decode (
    .slot (src_slot),
    .bg   (src_bg),
    .en   (dec_en),
    .we   (dec_we),
    .re   (dec_re),
    .data (dec_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= OPF_IDLE;
      elem_q    <= '0;
      bg_q      <= '0;
      idx       <= '0;
      op_ready  <= 1'b1;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_data  <= '0;
      mem_op    <= '0;
      mem_slot  <= '0;
      elem_done <= 1'b0;
    end else begin
      elem_done <= 1'b0;
      case (state)
        OPF_IDLE: begin
          if (op_valid && op_ready) begin
            elem_q <= op_in;
            bg_q   <= bg_in;
            idx    <= '0;
            if (dec_en) begin
              state     <= OPF_ISSUE;
              op_ready  <= 1'b0;
              mem_valid <= 1'b1;
              mem_we    <= dec_we;
              mem_re    <= dec_re;
              mem_data  <= dec_data;
              mem_op    <= src_slot;
              mem_slot  <= '0;
            end else begin
              elem_done <= 1'b1;
            end
          end
        end
        OPF_ISSUE: begin
          if (mem_ready) begin
            if (dec_en) begin
              idx       <= idx + 1'b1;
              mem_we    <= dec_we;
              mem_re    <= dec_re;
              mem_data  <= dec_data;
              mem_op    <= src_slot;
              mem_slot  <= idx + 1'b1;
            end else begin
              state     <= OPF_IDLE;
              op_ready  <= 1'b1;
              mem_valid <= 1'b0;
              mem_we    <= 1'b0;
              mem_re    <= 1'b0;
              mem_data  <= '0;
              mem_op    <= '0;
              mem_slot  <= '0;
              elem_done <= 1'b1;
            end
          end
        end
        default: state <= OPF_IDLE;
      endcase
    end
  end

endmodule
